// File: rtl/garden_input_ctrl.sv
// garden_input_ctrl: input front-end for the garden watering controller.
// Synchronises and debounces the start button and the 2-bit mode switch, and turns each
// debounced press into a valid/ready command carrying the switch value captured at the press.
// Optional feature: define GARDEN_INPUT_LONG_PRESS_EN to enable the long-press abort pulse.
module garden_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned CNT_W             = 20,
    parameter int unsigned BTN_ACTIVE_LOW    = 1,
    parameter int unsigned LONG_PRESS_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start_button,
    input  logic [1:0] i_switch,
    output logic       o_cmd_valid,
    input  logic       i_cmd_ready,
    output logic [1:0] o_cmd_mode,
    output logic       o_mode_changed,
    output logic       o_overrun,
    output logic       o_btn_level,
    output logic       o_abort
);

    // Raw level of the button when it is not pressed.
    localparam logic BTN_IDLE_RAW = (BTN_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef GARDEN_INPUT_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    typedef enum logic [1:0] {StRel = 2'd0, StPrs = 2'd1, StHold = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StRel = 2'd0, StPrs = 2'd1} state_e;
`endif

    logic             r_btn_meta;
    logic             r_btn_sync;
    logic [1:0]       r_sw_meta;
    logic [1:0]       r_sw_sync;
    logic             r_btn_stable;
    logic [CNT_W-1:0] r_btn_cnt;
    logic [1:0]       r_sw_stable;
    logic [CNT_W-1:0] r_sw_cnt;
    state_e           r_state;
    logic             r_cmd_valid;
    logic [1:0]       r_cmd_mode;
    logic             r_mode_changed;
    logic             r_overrun;

    logic w_btn_pressed;
    logic w_btn_diff;
    logic w_btn_accept;
    logic w_sw_diff;
    logic w_sw_accept;
    logic w_press_evt;
    logic w_release_evt;

    // Polarity-normalised synchronised button: 1 = pressed.
    assign w_btn_pressed = r_btn_sync ^ BTN_IDLE_RAW;
    assign w_btn_diff    = (w_btn_pressed != r_btn_stable);
    assign w_btn_accept  = w_btn_diff && (r_btn_cnt == DB_LAST);
    assign w_sw_diff     = (r_sw_sync != r_sw_stable);
    assign w_sw_accept   = w_sw_diff && (r_sw_cnt == DB_LAST);
    // Events are taken at the edge the stable value flips, so the command lands with btn_level.
    assign w_press_evt   = (r_state == StRel) && w_btn_accept && w_btn_pressed;
    assign w_release_evt = w_btn_accept && !w_btn_pressed;

    // Two-flop synchronisers; button flops reset to the released raw level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_meta <= BTN_IDLE_RAW;
            r_btn_sync <= BTN_IDLE_RAW;
            r_sw_meta  <= 2'b00;
            r_sw_sync  <= 2'b00;
        end else begin
            r_btn_meta <= i_start_button;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= i_switch;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // Button debounce: count while synced level differs, accept after DEBOUNCE_CYCLES.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_stable <= 1'b0;
            r_btn_cnt    <= '0;
        end else if (!w_btn_diff) begin
            r_btn_cnt <= '0;
        end else if (w_btn_accept) begin
            r_btn_stable <= w_btn_pressed;
            r_btn_cnt    <= '0;
        end else begin
            r_btn_cnt <= r_btn_cnt + 1'b1;
        end
    end

    // Switch debounce: whole vector shares one counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_stable <= 2'b00;
            r_sw_cnt    <= '0;
        end else if (!w_sw_diff) begin
            r_sw_cnt <= '0;
        end else if (w_sw_accept) begin
            r_sw_stable <= r_sw_sync;
            r_sw_cnt    <= '0;
        end else begin
            r_sw_cnt <= r_sw_cnt + 1'b1;
        end
    end

`ifdef GARDEN_INPUT_LONG_PRESS_EN
    logic             r_abort;
    logic [CNT_W-1:0] r_hold_cnt;
`endif

    // Button FSM with command handshake and registered pulse outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StRel;
            r_cmd_valid    <= 1'b0;
            r_cmd_mode     <= 2'b00;
            r_mode_changed <= 1'b0;
            r_overrun      <= 1'b0;
`ifdef GARDEN_INPUT_LONG_PRESS_EN
            r_abort        <= 1'b0;
            r_hold_cnt     <= '0;
`endif
        end else begin
            r_mode_changed <= w_sw_accept;
            r_overrun      <= 1'b0;
`ifdef GARDEN_INPUT_LONG_PRESS_EN
            r_abort        <= 1'b0;
`endif
            if (w_press_evt && (!r_cmd_valid || i_cmd_ready)) begin
                r_cmd_valid <= 1'b1;
                r_cmd_mode  <= r_sw_stable;
            end else begin
                if (w_press_evt) begin
                    r_overrun <= 1'b1;
                end
                if (r_cmd_valid && i_cmd_ready) begin
                    r_cmd_valid <= 1'b0;
                end
            end
            case (r_state)
                StRel: begin
                    if (w_press_evt) begin
                        r_state <= StPrs;
`ifdef GARDEN_INPUT_LONG_PRESS_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                StPrs: begin
                    if (w_release_evt) begin
                        r_state <= StRel;
`ifdef GARDEN_INPUT_LONG_PRESS_EN
                    end else if (r_hold_cnt == LP_LAST) begin
                        r_abort <= 1'b1;
                        r_state <= StHold;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
                    end
                end
`ifdef GARDEN_INPUT_LONG_PRESS_EN
                StHold: begin
                    if (w_release_evt) begin
                        r_state <= StRel;
                    end
                end
`endif
                default: r_state <= StRel;
            endcase
        end
    end

`ifdef GARDEN_INPUT_LONG_PRESS_EN
    assign o_abort = r_abort;
`else
    logic w_unused_long_press;
    assign w_unused_long_press = ^LONG_PRESS_CYCLES;
    assign o_abort = 1'b0;
`endif

    assign o_cmd_valid    = r_cmd_valid;
    assign o_cmd_mode     = r_cmd_mode;
    assign o_mode_changed = r_mode_changed;
    assign o_overrun      = r_overrun;
    assign o_btn_level    = r_btn_stable;

endmodule

// File: tb/tb_garden_input_ctrl.sv
// Directed bench for garden_input_ctrl (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, active-low key).
module tb_garden_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [1:0] sw;
    logic       ready;
    logic       cmd_valid;
    logic [1:0] cmd_mode;
    logic       mode_changed;
    logic       overrun;
    logic       btn_level;
    logic       abort_p;

    int n_checks = 0;
    int n_pass   = 0;
    int ov_cnt   = 0;
    int mc_cnt   = 0;
    int ab_cnt   = 0;
    int base;

    garden_input_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .CNT_W             (20),
        .BTN_ACTIVE_LOW    (1),
        .LONG_PRESS_CYCLES (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start_button (btn),
        .i_switch       (sw),
        .o_cmd_valid    (cmd_valid),
        .i_cmd_ready    (ready),
        .o_cmd_mode     (cmd_mode),
        .o_mode_changed (mode_changed),
        .o_overrun      (overrun),
        .o_btn_level    (btn_level),
        .o_abort        (abort_p)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (overrun)      ov_cnt++;
        if (mode_changed) mc_cnt++;
        if (abort_p)      ab_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        sw    = 2'b00;
        ready = 1'b0;

        // 1. Reset state, then a 2-cycle low blip after release gives no command.
        tick(3);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_mode", 32'(cmd_mode), 32'd0);
        check("rst_mchg", 32'(mode_changed), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_lvl", 32'(btn_level), 32'd0);
        check("rst_abort", 32'(abort_p), 32'd0);
        rst_n = 1'b1;
        tick(2);
        btn = 1'b1;
        tick(12);
        check("t1_no_valid", 32'(cmd_valid), 32'd0);
        check("t1_no_lvl", 32'(btn_level), 32'd0);

        // 2. Clean press with switch=10: command after exactly 6 edges, held while not ready.
        base = mc_cnt;
        sw = 2'b10;
        tick(8);
        check("t2_mchg_cnt", 32'(mc_cnt - base), 32'd1);
        btn = 1'b0;
        tick(5);
        check("t2_valid_early", 32'(cmd_valid), 32'd0);
        check("t2_lvl_early", 32'(btn_level), 32'd0);
        tick(1);
        check("t2_valid", 32'(cmd_valid), 32'd1);
        check("t2_lvl", 32'(btn_level), 32'd1);
        check("t2_mode", 32'(cmd_mode), 32'd2);
        tick(20);
        check("t2_valid_hold", 32'(cmd_valid), 32'd1);
        check("t2_mode_hold", 32'(cmd_mode), 32'd2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("t2_accept", 32'(cmd_valid), 32'd0);
        btn = 1'b1;
        tick(8);
        check("t2_release", 32'(btn_level), 32'd0);

        // 3. Bounce for 20 cycles then settle pressed: one command, no overrun.
        base = ov_cnt;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b0;
            tick(2);
            btn = 1'b1;
            tick(2);
        end
        check("t3_no_valid_bounce", 32'(cmd_valid), 32'd0);
        btn = 1'b0;
        tick(5);
        check("t3_valid_early", 32'(cmd_valid), 32'd0);
        tick(1);
        check("t3_valid", 32'(cmd_valid), 32'd1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(10);
        check("t3_single_cmd", 32'(cmd_valid), 32'd0);
        check("t3_no_ovr", 32'(ov_cnt - base), 32'd0);
        btn = 1'b1;
        tick(8);

        // 4. Overrun on a second press while pending; then press on a ready edge replaces it.
        sw = 2'b01;
        tick(8);
        btn = 1'b0;
        tick(6);
        check("t4_mode_first", 32'(cmd_mode), 32'd1);
        btn = 1'b1;
        tick(8);
        sw = 2'b11;
        tick(8);
        check("t4_mode_keep_sw", 32'(cmd_mode), 32'd1);
        base = ov_cnt;
        btn = 1'b0;
        tick(6);
        check("t4_ovr_pulse", 32'(overrun), 32'd1);
        check("t4_mode_keep", 32'(cmd_mode), 32'd1);
        check("t4_valid_keep", 32'(cmd_valid), 32'd1);
        tick(1);
        check("t4_ovr_end", 32'(overrun), 32'd0);
        check("t4_ovr_cnt", 32'(ov_cnt - base), 32'd1);
        btn = 1'b1;
        tick(8);
        sw = 2'b10;
        tick(8);
        base = ov_cnt;
        btn = 1'b0;
        tick(5);
        check("t4_pending", 32'(cmd_valid), 32'd1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("t4_valid_same_edge", 32'(cmd_valid), 32'd1);
        check("t4_mode_new", 32'(cmd_mode), 32'd2);
        check("t4_no_ovr", 32'(ov_cnt - base + 32'(overrun)), 32'd0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("t4_accept", 32'(cmd_valid), 32'd0);
        btn = 1'b1;
        tick(8);

        // 5. Switch change pulse latency, 3-cycle glitch filtered, 4-cycle glitch accepted.
        sw = 2'b00;
        tick(8);
        base = mc_cnt;
        sw = 2'b11;
        tick(5);
        check("t5_mchg_early", 32'(mode_changed), 32'd0);
        tick(1);
        check("t5_mchg", 32'(mode_changed), 32'd1);
        tick(1);
        check("t5_mchg_end", 32'(mode_changed), 32'd0);
        check("t5_mchg_cnt", 32'(mc_cnt - base), 32'd1);
        check("t5_mode_idle", 32'(cmd_mode), 32'd2);
        base = mc_cnt;
        sw = 2'b01;
        tick(3);
        sw = 2'b11;
        tick(12);
        check("t5_glitch3", 32'(mc_cnt - base), 32'd0);
        base = mc_cnt;
        sw = 2'b00;
        tick(4);
        sw = 2'b11;
        tick(12);
        check("t5_glitch4", 32'(mc_cnt - base), 32'd2);

        // 6. Long press.
        base = ab_cnt;
        btn = 1'b0;
        tick(6);
        check("t6_lvl", 32'(btn_level), 32'd1);
        check("t6_valid", 32'(cmd_valid), 32'd1);
        check("t6_mode", 32'(cmd_mode), 32'd3);
`ifdef GARDEN_INPUT_LONG_PRESS_EN
        tick(15);
        check("t6_abort_early", 32'(abort_p), 32'd0);
        tick(1);
        check("t6_abort", 32'(abort_p), 32'd1);
        tick(1);
        check("t6_abort_end", 32'(abort_p), 32'd0);
        tick(14);
        check("t6_abort_once", 32'(ab_cnt - base), 32'd1);
        check("t6_valid_kept", 32'(cmd_valid), 32'd1);
        btn = 1'b1;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(8);
        btn = 1'b0;
        tick(6);
        check("t6_lvl2", 32'(btn_level), 32'd1);
        tick(10);
        btn = 1'b1;
        tick(12);
        check("t6_short_no_abort", 32'(ab_cnt - base), 32'd1);
`else
        tick(30);
        check("t6_abort_tied", 32'(abort_p), 32'd0);
        check("t6_abort_cnt", 32'(ab_cnt - base), 32'd0);
        check("t6_valid_kept", 32'(cmd_valid), 32'd1);
        btn = 1'b1;
        tick(8);
`endif
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("t6_accept", 32'(cmd_valid), 32'd0);

        // 7. Asynchronous reset while a command is pending and the button is held.
        btn = 1'b0;
        tick(6);
        check("t7_valid", 32'(cmd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t7_async_clear", 32'(cmd_valid), 32'd0);
        check("t7_lvl_clear", 32'(btn_level), 32'd0);
        btn = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(12);
        check("t7_no_cmd", 32'(cmd_valid), 32'd0);
        btn = 1'b0;
        tick(6);
        check("t7_repress", 32'(cmd_valid), 32'd1);
        check("t7_mode", 32'(cmd_mode), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
